rom_stream_reader: RTL

Sequencer that sits directly in front of the synchronous `rom` block: it drives the ROM's `ce`/`address` port and consumes its registered `q`. It reads a run of consecutive words and presents them as a valid/ready stream to pattern and tile renderers. It hides the ROM's one-cycle read latency behind a small credit-controlled FIFO, so downstream backpressure never drops or duplicates a word.

---
 rtl/rom_stream_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rom_stream_reader.sv
// Reads a run of consecutive ROM words and streams them out as valid/ready.
// A credit check against a small FIFO hides the ROM's one-cycle read latency.
module rom_stream_reader #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] length,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rom_ce,
    output logic [AW-1:0] rom_address,
    input  logic [DW-1:0] rom_q,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0] addr;
    logic [AW-1:0] remaining;
    logic          inflight;
    logic          inflight_last;
    logic          done_q;
    logic          done_nx;

    logic [DEPTH-1:0][DW-1:0] fifo_data;
    logic [DEPTH-1:0]         fifo_last;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic [CW-1:0]            count;

    logic issue;
    logic last_issue;
    logic push;
    logic pop;
    logic flush;
    logic head_last;

    // A read still in flight already owns a FIFO slot.
    assign issue = (state == RUN) && (remaining != '0)
                   && ((count + CW'(inflight)) < CW'(DEPTH));
    assign last_issue = issue && (remaining == AW'(1));
    assign push       = inflight;
    assign pop        = out_valid && out_ready;
    assign flush      = abort && (state != IDLE);
    assign head_last  = fifo_last[rd_ptr];

    assign rom_ce      = issue;
    assign rom_address = addr;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign out_valid   = (count != '0);
    assign out_data    = fifo_data[rd_ptr];
    assign out_last    = out_valid && head_last;

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last_issue) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pop && head_last) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && start) begin
            addr      <= base_addr;
            remaining <= length;
        end else if (issue) begin
            addr      <= addr + AW'(1);
            remaining <= remaining - AW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue && !flush;
            inflight_last <= last_issue && !flush;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data <= '0;
            fifo_last <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_q;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
